// File: rtl/trap_pkg.sv
// Shared types and constants for the machine-mode trap sequencer.
// Latency: none (declarations only).
// Backpressure: not applicable.
package trap_pkg;

    typedef enum logic [2:0] {
        IDLE,
        DRAIN,
        ENTER,
        HANDLER,
        EXIT
    } trap_state_t;

    localparam logic [3:0]  CAUSE_ILLEGAL        = 4'd2;
    localparam logic [3:0]  CAUSE_ECALL_M        = 4'd11;
    localparam logic [31:0] HANDLER_BASE_DEFAULT = 32'h1c09_0000;

    // Return address skips the trapping instruction; wraps at 2^32.
    function automatic logic [31:0] return_pc(input logic [31:0] epc);
        return epc + 32'd4;
    endfunction

endpackage

// File: rtl/redirect_port.sv
// Holds one fetch redirect (valid + target) until fetch accepts it.
// Latency: valid rises the edge after load; clears on the handshake edge.
// Backpressure: valid/pc held stable while ready is low; fire = valid & ready.
module redirect_port (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic [31:0] load_pc,
    input  logic        ready,
    output logic        valid,
    output logic [31:0] pc,
    output logic        fire
);

    assign fire = valid & ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= 1'b0;
            pc    <= 32'd0;
        end else if (load) begin
            valid <= 1'b1;
            pc    <= load_pc;
        end else if (fire) begin
            valid <= 1'b0;
            pc    <= 32'd0;
        end
    end

endmodule

// File: rtl/trap_sequencer.sv
// Sequences trap entry/exit to the M-mode handler ROM; optional watchdog under TRAP_WATCHDOG_EN.
// Latency: trap to handler redirect handshake in FLUSH_CYCLES+1 cycles with ready high.
// Backpressure: redirects wait in ENTER/EXIT until redirect_ready; EX requests ignored meanwhile.
module trap_sequencer
    import trap_pkg::*;
#(
    parameter logic [31:0] HANDLER_BASE = HANDLER_BASE_DEFAULT,
    parameter int          FLUSH_CYCLES = 2
`ifdef TRAP_WATCHDOG_EN
    ,
    parameter int          WDOG_CYCLES  = 1024
`endif
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        trap_req,
    input  logic [3:0]  trap_cause,
    input  logic [31:0] trap_pc,
    input  logic        mret_req,
    input  logic        redirect_ready,
    output logic        flush,
    output logic        stall,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc,
    output logic        in_handler,
    output logic [31:0] mepc,
    output logic [3:0]  mcause,
    output logic        double_fault
`ifdef TRAP_WATCHDOG_EN
    ,
    output logic        wdog_expired
`endif
);

    trap_state_t state, state_n;
    logic [3:0]  drain_cnt;
    logic        exit_first;
    logic        latch_trap;
    logic        set_df;
    logic        rd_load;
    logic [31:0] rd_pc;
    logic        rd_fire;
    logic        wdog_hit;

`ifdef TRAP_WATCHDOG_EN
    logic [31:0] wdog_cnt;

    assign wdog_hit = (state == HANDLER) && (wdog_cnt == 32'(WDOG_CYCLES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wdog_cnt     <= 32'd0;
            wdog_expired <= 1'b0;
        end else begin
            if (state == ENTER) begin
                wdog_cnt <= 32'd0;
            end else if (state == HANDLER) begin
                wdog_cnt <= wdog_cnt + 32'd1;
            end
            if (wdog_hit) begin
                wdog_expired <= 1'b1;
            end
        end
    end
`else
    assign wdog_hit = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n    = state;
        latch_trap = 1'b0;
        set_df     = 1'b0;
        rd_load    = 1'b0;
        rd_pc      = HANDLER_BASE;
        flush      = 1'b0;
        stall      = 1'b0;
        in_handler = 1'b0;
        case (state)
            IDLE: begin
                // mret alone is meaningless outside the handler; a trap beats a coincident mret.
                if (trap_req) begin
                    latch_trap = 1'b1;
                    state_n    = DRAIN;
                end
            end
            DRAIN: begin
                flush = 1'b1;
                stall = 1'b1;
                if (drain_cnt == 4'd1) begin
                    rd_load = 1'b1;
                    state_n = ENTER;
                end
            end
            ENTER: begin
                stall = 1'b1;
                if (rd_fire) begin
                    state_n = HANDLER;
                end
            end
            HANDLER: begin
                in_handler = 1'b1;
                set_df     = trap_req & ~mret_req;
                if (mret_req || wdog_hit) begin
                    rd_load = 1'b1;
                    rd_pc   = return_pc(mepc);
                    state_n = EXIT;
                end
            end
            EXIT: begin
                in_handler = 1'b1;
                stall      = 1'b1;
                flush      = exit_first;
                if (rd_fire) begin
                    state_n = IDLE;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mepc         <= 32'd0;
            mcause       <= 4'd0;
            double_fault <= 1'b0;
            drain_cnt    <= 4'd0;
            exit_first   <= 1'b0;
        end else begin
            if (latch_trap) begin
                mepc      <= trap_pc;
                mcause    <= trap_cause;
                drain_cnt <= 4'(FLUSH_CYCLES);
            end else if (state == DRAIN) begin
                drain_cnt <= drain_cnt - 4'd1;
            end
            if (set_df) begin
                double_fault <= 1'b1;
            end
            exit_first <= (state_n == EXIT) && (state != EXIT);
        end
    end

    redirect_port u_redirect_port (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (rd_load),
        .load_pc (rd_pc),
        .ready   (redirect_ready),
        .valid   (redirect_valid),
        .pc      (redirect_pc),
        .fire    (rd_fire)
    );

endmodule
